// File: rtl/chk_console_tx.sv
`default_nettype none
// ============================================================================
// Module : chk_console_tx
// Brief  : Serialises queued console commands into held 16-bit checkbit codes.
// Rev    : 1.0
// ============================================================================
module chk_console_tx #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_type_i,
    input  logic [7:0]                    cmd_data_i,
    output logic [15:0]                   chk_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0] c_TYPE_CHAR  = 2'd0;
    localparam logic [1:0] c_TYPE_START = 2'd1;
    localparam logic [1:0] c_TYPE_PASS  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic [9:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]    r_wr_ptr;
    logic [c_PTR_W:0]    r_rd_ptr;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [15:0]         r_chk;
    logic [15:0]         w_chk_nxt;
    logic                r_final;
    logic                w_final_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_empty;
    logic                w_full;
    logic [9:0]          w_head;
    logic [15:0]         w_head_code;
    logic                w_head_final;

    // Extra wrap bit on each pointer separates full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    assign cmd_ready_o  = !w_full && (r_state != ST_DONE);
    assign w_push       = cmd_valid_i && cmd_ready_o;
    assign fifo_level_o = r_wr_ptr - r_rd_ptr;
    assign done_o       = (r_state == ST_DONE);
    assign busy_o       = (r_state != ST_DONE) && (!w_empty || (r_state != ST_IDLE));
    assign chk_o        = r_chk;

    assign w_head       = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_final = w_head[9];  // pass and fail both have type bit 1 set

    always_comb begin
        w_head_code = 16'hAF00;
        case (w_head[9:8])
            c_TYPE_CHAR:  w_head_code = {8'hA1, w_head[7:0]};
            c_TYPE_START: w_head_code = 16'hA000;
            c_TYPE_PASS:  w_head_code = 16'hAB00;
            default:      w_head_code = 16'hAF00;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {cmd_type_i, cmd_data_i};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_chk   <= 16'h0000;
            r_final <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chk   <= w_chk_nxt;
            r_final <= w_final_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chk_nxt   = r_chk;
        w_final_nxt = r_final;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_chk_nxt = 16'h0000;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_chk_nxt   = w_head_code;
                    w_final_nxt = w_head_final;
                    w_cnt_nxt   = c_HOLD_LOAD;
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == '0) begin
                    if (r_final) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_chk_nxt   = 16'h0000;
                        w_cnt_nxt   = c_GAP_LOAD;
                        w_state_nxt = ST_GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    // Back-to-back reload keeps the stream period at hold + gap.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_chk_nxt   = w_head_code;
                        w_final_nxt = w_head_final;
                        w_cnt_nxt   = c_HOLD_LOAD;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_DONE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_chk_console_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_chk_console_tx
// Brief  : Scoreboard bench for chk_console_tx (directed command vectors).
// Rev    : 1.0
// ============================================================================
module tb_chk_console_tx;

    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i = 2'd0;
    logic [7:0]  cmd_data_i = 8'h00;
    logic [15:0] chk_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  fifo_level_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    int          last_gap = 0;

    chk_console_tx #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_type_i   (cmd_type_i),
        .cmd_data_i   (cmd_data_i),
        .chk_o        (chk_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [15:0] code_of(input logic [1:0] t, input logic [7:0] d);
        case (t)
            2'd0:    return {8'hA1, d};
            2'd1:    return 16'hA000;
            2'd2:    return 16'hAB00;
            default: return 16'hAF00;
        endcase
    endfunction

    // Drive one command until accepted; optionally queue the code it must produce.
    task automatic send(input logic [1:0] t, input logic [7:0] d, input bit shown);
        bit ok = 0;
        cmd_type_i  = t;
        cmd_data_i  = d;
        cmd_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (ok && shown) exp_q.push_back(code_of(t, d));
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!busy_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("idle_timeout", {31'd0, ok}, 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("done_timeout", {31'd0, ok}, 1);
    endtask

    task automatic pulse_reset();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
    endtask

    // Monitor: every new nonzero code is popped from the scoreboard; run lengths are checked.
    initial begin
        logic [15:0] prev = 16'h0000;
        int          len  = 0;
        bit          seen = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                prev = 16'h0000;
                len  = 0;
                seen = 0;
            end else if (chk_o == prev) begin
                len++;
            end else begin
                if (prev != 16'h0000) begin
                    check("hold_len", len, HOLD);
                end else if (seen) begin
                    last_gap = len;
                    n_checks++;
                    if (len < GAP) begin
                        n_errors++;
                        $display("FAIL gap_len: got %0d expected >= %0d", len, GAP);
                    end
                end
                if (chk_o != 16'h0000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_code", {16'h0, chk_o}, 32'h0);
                    end else begin
                        check("code", {16'h0, chk_o}, {16'h0, exp_q.pop_front()});
                    end
                    seen = 1;
                end
                prev = chk_o;
                len  = 1;
            end
        end
    end

    initial begin
        int         idx;
        int         bad;
        logic [7:0] cd;

        // Reset with random pending valid
        for (int i = 0; i < 3; i++) begin
            cmd_valid_i = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_valid_i = 1'b0;
        wb_rst_i    = 1'b0;
        check("rst_chk",   {16'h0, chk_o}, 32'h0);
        check("rst_ready", {31'h0, cmd_ready_o}, 1);
        check("rst_level", {29'h0, fifo_level_o}, 0);
        check("rst_busy",  {31'h0, busy_o}, 0);
        check("rst_done",  {31'h0, done_o}, 0);

        // Single char latency, hold and gap
        send(2'd0, 8'h48, 1);
        check("single_level", {29'h0, fifo_level_o}, 1);
        check("single_pre",   {16'h0, chk_o}, 32'h0);
        tick();
        check("single_first", {16'h0, chk_o}, 32'hA148);
        check("single_busy",  {31'h0, busy_o}, 1);
        repeat (HOLD - 1) tick();
        check("single_last",  {16'h0, chk_o}, 32'hA148);
        tick();
        check("single_gap",   {16'h0, chk_o}, 32'h0);
        repeat (GAP - 1) tick();
        check("single_gapbusy", {31'h0, busy_o}, 1);
        tick();
        check("single_idle",  {31'h0, busy_o}, 0);

        // Repeated identical chars stream with exactly one gap between them
        send(2'd0, 8'h6C, 1);
        send(2'd0, 8'h6C, 1);
        wait_idle();
        check("repeat_gap", last_gap, GAP);

        // Valid held through a full FIFO
        cmd_type_i  = 2'd0;
        cmd_valid_i = 1'b1;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            cd = 8'h30 + 8'(idx);
            cmd_data_i = cd;
            if (cmd_ready_o) begin
                exp_q.push_back({8'hA1, cd});
                idx++;
            end
            tick();
        end
        check("full_accepted", idx, 5);
        check("full_ready",    {31'h0, cmd_ready_o}, 0);
        check("full_level",    {29'h0, fifo_level_o}, 4);
        cmd_valid_i = 1'b0;
        wait_idle();

        // start, char, pass then sticky DONE
        send(2'd1, 8'h00, 1);
        send(2'd0, 8'h41, 1);
        send(2'd2, 8'h00, 1);
        wait_done();
        check("pass_chk",   {16'h0, chk_o}, 32'hAB00);
        check("pass_ready", {31'h0, cmd_ready_o}, 0);
        check("pass_busy",  {31'h0, busy_o}, 0);
        cmd_type_i  = 2'd0;
        cmd_data_i  = 8'h5A;
        cmd_valid_i = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (cmd_ready_o) bad++;
            tick();
        end
        cmd_valid_i = 1'b0;
        check("done_no_accept", bad, 0);
        check("done_level",     {29'h0, fifo_level_o}, 0);
        check("done_hold",      {16'h0, chk_o}, 32'hAB00);
        check("done_sticky",    {31'h0, done_o}, 1);

        // Reset out of DONE, then fail
        pulse_reset();
        check("rstdone_chk",   {16'h0, chk_o}, 32'h0);
        check("rstdone_done",  {31'h0, done_o}, 0);
        check("rstdone_ready", {31'h0, cmd_ready_o}, 1);
        send(2'd3, 8'h00, 1);
        wait_done();
        check("fail_chk",  {16'h0, chk_o}, 32'hAF00);
        check("fail_done", {31'h0, done_o}, 1);
        pulse_reset();
        check("rstfail_chk",  {16'h0, chk_o}, 32'h0);
        check("rstfail_done", {31'h0, done_o}, 0);

        // Reset mid-SHOW discards queued codes
        send(2'd0, 8'h61, 1);
        send(2'd0, 8'h62, 0);
        send(2'd0, 8'h63, 0);
        send(2'd0, 8'h64, 0);
        check("midshow_level", {29'h0, fifo_level_o}, 3);
        check("midshow_chk",   {16'h0, chk_o}, 32'hA161);
        pulse_reset();
        check("midrst_chk",   {16'h0, chk_o}, 32'h0);
        check("midrst_level", {29'h0, fifo_level_o}, 0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (chk_o != 16'h0000) bad++;
            tick();
        end
        check("midrst_quiet", bad, 0);
        check("midrst_busy",  {31'h0, busy_o}, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
